// File: rtl/tx_sequence_recorder_if.sv
// Write/read channel between the TX arbiter, its FSM and the grant-sequence recorder.
// The master side is the arbiter plus FSM; the slave side is the recorder storage.
interface tx_sequence_recorder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);

  logic                  wr_en;
  logic [2:0]            wr_mode;
  logic [DATA_WIDTH-1:0] wr_data_1;
  logic [DATA_WIDTH-1:0] wr_data_2;
  logic [DATA_WIDTH-1:0] wr_data_3;
  logic [DATA_WIDTH-1:0] wr_data_4;
  logic                  rd_en;
  logic [1:0]            rd_mode;
  logic [DATA_WIDTH-1:0] rd_data_1;
  logic [DATA_WIDTH-1:0] rd_data_2;
  logic [ADDR_WIDTH:0]   available;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4, rd_en, rd_mode,
    input  rd_data_1, rd_data_2, available, overflow_err, underflow_err
  );

  modport slave (
    input  wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4, rd_en, rd_mode,
    output rd_data_1, rd_data_2, available, overflow_err, underflow_err
  );
endinterface

// File: rtl/tx_sequence_recorder.sv
// Multi-push / multi-pop FIFO recording the TX arbiter grant order.
// Registered writes of 1-4 entries, first-word fall-through reads of 1-2 entries.
module tx_sequence_recorder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input logic                  clk,
  input logic                  arst,
  tx_sequence_recorder_if.slave bus
);
  localparam int unsigned CntW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wdata [4];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW-1:0]       space, w_cnt, r_cnt, w_acc, r_acc;
  logic                  ovf_q, ovf_d, udf_q, udf_d;

  assign wdata[0] = bus.wr_data_1;
  assign wdata[1] = bus.wr_data_2;
  assign wdata[2] = bus.wr_data_3;
  assign wdata[3] = bus.wr_data_4;

  always_comb begin
    w_cnt = '0;
    r_cnt = '0;
    if (bus.wr_en && (bus.wr_mode inside {3'd1, 3'd2, 3'd3, 3'd4})) w_cnt = CntW'(bus.wr_mode);
    if (bus.rd_en && (bus.rd_mode inside {2'd1, 2'd2}))             r_cnt = CntW'(bus.rd_mode);

    // Acceptance uses the pre-edge count only; same-cycle traffic is never credited.
    space = CntW'(FIFO_DEPTH) - count_q;
    w_acc = (w_cnt <= space)   ? w_cnt : '0;
    r_acc = (r_cnt <= count_q) ? r_cnt : '0;
    ovf_d = ovf_q | (w_cnt > space);
    udf_d = udf_q | (r_cnt > count_q);

    mem_d = mem_q;
    for (int k = 0; k < 4; k++) begin
      if (CntW'(k) < w_acc) mem_d[wr_ptr_q + ADDR_WIDTH'(k)] = wdata[k];
    end

    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(w_acc);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(r_acc);
    count_d  = count_q + w_acc - r_acc;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.rd_data_1     = (count_q >= CntW'(1)) ? mem_q[rd_ptr_q] : '0;
  assign bus.rd_data_2     = (count_q >= CntW'(2)) ? mem_q[rd_ptr_q + ADDR_WIDTH'(1)] : '0;
  assign bus.available     = count_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;
endmodule
